// File: rtl/bicubic_frame_scheduler.sv
// Frame-level valid/ready gate between the access controller and bicubic_processing_element.
// Optional stall/starve performance counters are enabled by defining UPSP_STALL_CNT_EN.
module bicubic_frame_scheduler #(
  parameter int unsigned BLOCK_SIZE          = 960,
  parameter int unsigned SRC_IMG_HEIGHT      = 540,
  parameter int unsigned OUT_BEATS_PER_PIXEL = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  output logic        busy,
  output logic        done,
  input  logic        ac_upsp_rvalid,
  output logic        upsp_ac_rready,
  output logic        pe_rvalid,
  input  logic        pe_rready,
  input  logic        pe_wvalid,
  output logic        pe_wready,
  output logic        upsp_ac_wvalid,
  input  logic        ac_upsp_wready
`ifdef UPSP_STALL_CNT_EN
  ,
  output logic [31:0] stall_cnt,
  output logic [31:0] starve_cnt
`endif
);

  localparam int unsigned IN_TOTAL  = BLOCK_SIZE * SRC_IMG_HEIGHT;
  localparam int unsigned OUT_TOTAL = IN_TOTAL * OUT_BEATS_PER_PIXEL;
  localparam int unsigned IN_W      = $clog2(IN_TOTAL + 1);
  localparam int unsigned OUT_W     = $clog2(OUT_TOTAL + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_e;

  state_e           state_q;
  logic [IN_W-1:0]  in_cnt_q;
  logic [IN_W-1:0]  in_cnt_d;
  logic [OUT_W-1:0] out_cnt_q;
  logic [OUT_W-1:0] out_cnt_d;
  logic             done_q;
  logic             in_open;
  logic             out_open;
  logic             rd_hs;
  logic             wr_hs;

  // Gates and next counter values; a handshake can only occur while the gate is open,
  // so the increments below can never carry past the totals.
  always_comb begin
    in_open        = (state_q == S_RUN) && (in_cnt_q < IN_W'(IN_TOTAL));
    out_open       = (state_q != S_IDLE) && (out_cnt_q < OUT_W'(OUT_TOTAL));
    pe_rvalid      = ac_upsp_rvalid & in_open;
    upsp_ac_rready = pe_rready & in_open;
    upsp_ac_wvalid = pe_wvalid & out_open;
    pe_wready      = ac_upsp_wready & out_open;
    rd_hs          = ac_upsp_rvalid & upsp_ac_rready;
    wr_hs          = upsp_ac_wvalid & ac_upsp_wready;
    in_cnt_d       = in_cnt_q;
    out_cnt_d      = out_cnt_q;
    if (rd_hs) in_cnt_d = in_cnt_q + IN_W'(1);
    if (wr_hs) out_cnt_d = out_cnt_q + OUT_W'(1);
  end

  // Frame sequencer: admit IN_TOTAL pixels, then wait for OUT_TOTAL beats.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      in_cnt_q  <= '0;
      out_cnt_q <= '0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q   <= S_RUN;
            in_cnt_q  <= '0;
            out_cnt_q <= '0;
          end
        end
        S_RUN: begin
          if (abort) begin
            state_q   <= S_IDLE;
            in_cnt_q  <= '0;
            out_cnt_q <= '0;
          end else begin
            in_cnt_q  <= in_cnt_d;
            out_cnt_q <= out_cnt_d;
            if (in_cnt_d == IN_W'(IN_TOTAL)) state_q <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (abort) begin
            state_q   <= S_IDLE;
            in_cnt_q  <= '0;
            out_cnt_q <= '0;
          end else begin
            out_cnt_q <= out_cnt_d;
            // Also covers outputs that completed while inputs were still arriving.
            if (out_cnt_d == OUT_W'(OUT_TOTAL)) begin
              state_q <= S_IDLE;
              done_q  <= 1'b1;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy = (state_q != S_IDLE);
  assign done = done_q;

`ifdef UPSP_STALL_CNT_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] starve_cnt_q;
  logic        start_acc;

  assign start_acc = (state_q == S_IDLE) && start;

  // Saturating back-pressure and input-starvation counters, cleared per frame.
  always_ff @(posedge clk) begin
    if (!rst_n || start_acc) begin
      stall_cnt_q  <= '0;
      starve_cnt_q <= '0;
    end else begin
      if (upsp_ac_wvalid && !ac_upsp_wready && (stall_cnt_q != 32'hFFFF_FFFF))
        stall_cnt_q <= stall_cnt_q + 32'd1;
      if (in_open && !ac_upsp_rvalid && (starve_cnt_q != 32'hFFFF_FFFF))
        starve_cnt_q <= starve_cnt_q + 32'd1;
    end
  end

  assign stall_cnt  = stall_cnt_q;
  assign starve_cnt = starve_cnt_q;
`endif

endmodule

// File: tb/tb_bicubic_frame_scheduler.sv
// Randomized self-checking bench for bicubic_frame_scheduler against a frame-level model.
// Define UPSP_STALL_CNT_EN to also check the stall/starve counters.
module tb_bicubic_frame_scheduler;

  localparam int IN_TOTAL  = 8;
  localparam int OUT_TOTAL = 32;

  logic clk;
  logic rst_n;
  logic start;
  logic abort;
  logic busy;
  logic done;
  logic ac_upsp_rvalid;
  logic upsp_ac_rready;
  logic pe_rvalid;
  logic pe_rready;
  logic pe_wvalid;
  logic pe_wready;
  logic upsp_ac_wvalid;
  logic ac_upsp_wready;
`ifdef UPSP_STALL_CNT_EN
  logic [31:0] stall_cnt;
  logic [31:0] starve_cnt;
`endif

  bicubic_frame_scheduler #(
    .BLOCK_SIZE(4),
    .SRC_IMG_HEIGHT(2),
    .OUT_BEATS_PER_PIXEL(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .abort(abort),
    .busy(busy),
    .done(done),
    .ac_upsp_rvalid(ac_upsp_rvalid),
    .upsp_ac_rready(upsp_ac_rready),
    .pe_rvalid(pe_rvalid),
    .pe_rready(pe_rready),
    .pe_wvalid(pe_wvalid),
    .pe_wready(pe_wready),
    .upsp_ac_wvalid(upsp_ac_wvalid),
    .ac_upsp_wready(ac_upsp_wready)
`ifdef UPSP_STALL_CNT_EN
    ,
    .stall_cnt(stall_cnt),
    .starve_cnt(starve_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Frame-level model: is a frame in flight, how many pixels/beats it has moved.
  bit          m_active = 1'b0;
  bit          m_done   = 1'b0;
  int          m_in     = 0;
  int          m_out    = 0;
  logic [31:0] m_stall  = '0;
  logic [31:0] m_starve = '0;

  int dut_rd   = 0;
  int dut_wr   = 0;
  int dut_done = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // One clock: drive inputs after negedge, check outputs, then advance the model.
  task automatic step(input bit st, input bit ab, input bit rv, input bit rr,
                      input bit wv, input bit wr, input bit rstn);
    bit exp_in_open;
    bit exp_out_open;
    bit rd;
    bit wh;
    bit inputs_were_complete;
    @(negedge clk);
    start          = st;
    abort          = ab;
    ac_upsp_rvalid = rv;
    pe_rready      = rr;
    pe_wvalid      = wv;
    ac_upsp_wready = wr;
    rst_n          = rstn;
    #1;
    exp_in_open  = m_active && (m_in < IN_TOTAL);
    exp_out_open = m_active && (m_out < OUT_TOTAL);
    check_eq("pe_rvalid",      32'(pe_rvalid),      32'(rv & exp_in_open));
    check_eq("upsp_ac_rready", 32'(upsp_ac_rready), 32'(rr & exp_in_open));
    check_eq("upsp_ac_wvalid", 32'(upsp_ac_wvalid), 32'(wv & exp_out_open));
    check_eq("pe_wready",      32'(pe_wready),      32'(wr & exp_out_open));
    check_eq("busy",           32'(busy),           32'(m_active));
    check_eq("done",           32'(done),           32'(m_done));
`ifdef UPSP_STALL_CNT_EN
    check_eq("stall_cnt",  stall_cnt,  m_stall);
    check_eq("starve_cnt", starve_cnt, m_starve);
`endif
    dut_rd   += int'(ac_upsp_rvalid & upsp_ac_rready);
    dut_wr   += int'(upsp_ac_wvalid & ac_upsp_wready);
    dut_done += int'(done);

    rd = rv & rr & exp_in_open;
    wh = wv & wr & exp_out_open;
    if (!rstn || (!m_active && st)) begin
      m_stall  = '0;
      m_starve = '0;
    end else begin
      if (wv && !wr && exp_out_open && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 32'd1;
      if (exp_in_open && !rv && m_starve != 32'hFFFF_FFFF) m_starve = m_starve + 32'd1;
    end

    m_done = 1'b0;
    if (!rstn) begin
      m_active = 1'b0;
      m_in     = 0;
      m_out    = 0;
    end else if (!m_active) begin
      if (st) begin
        m_active = 1'b1;
        m_in     = 0;
        m_out    = 0;
      end
    end else if (ab) begin
      m_active = 1'b0;
      m_in     = 0;
      m_out    = 0;
    end else begin
      // A frame completes once all pixels were in on an earlier cycle and all beats are out.
      inputs_were_complete = (m_in == IN_TOTAL);
      m_in  += int'(rd);
      m_out += int'(wh);
      if (inputs_were_complete && m_out == OUT_TOTAL) begin
        m_active = 1'b0;
        m_done   = 1'b1;
      end
    end
  endtask

  task automatic clear_counts();
    dut_rd   = 0;
    dut_wr   = 0;
    dut_done = 0;
  endtask

  task automatic reset_cycle();
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Feed inputs at full rate; PE always offers output; AC write ready at wr_pct percent.
  task automatic run_until_done(input int budget, input int wr_pct, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, ($urandom % 100) < wr_pct, 1'b1);
      if (done) seen = 1'b1;
    end
  endtask

  bit seen;
  int gap;

  initial begin
    start          = 1'b0;
    abort          = 1'b0;
    ac_upsp_rvalid = 1'b0;
    pe_rready      = 1'b0;
    pe_wvalid      = 1'b0;
    ac_upsp_wready = 1'b0;
    rst_n          = 1'b0;
    repeat (3) @(posedge clk);

    // 1: no start -> gates stay closed
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    check_eq("idle_rready", 32'(upsp_ac_rready), 32'd0);
    check_eq("idle_rvalid", 32'(pe_rvalid), 32'd0);
    check_eq("idle_busy",   32'(busy), 32'd0);

    // 2: full-rate frame
    clear_counts();
    step(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    run_until_done(200, 100, seen);
    check_eq("t2_done_seen", 32'(seen), 32'd1);
    check_eq("t2_busy_at_done", 32'(busy), 32'd0);
    check_eq("t2_rd_hs", 32'(dut_rd), 32'(IN_TOTAL));
    check_eq("t2_wr_hs", 32'(dut_wr), 32'(OUT_TOTAL));
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    check_eq("t2_done_once", 32'(dut_done), 32'd1);

    // 3: random write back-pressure, then a 33rd beat offered after done
    clear_counts();
    step(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    run_until_done(600, 50, seen);
    check_eq("t3_done_seen", 32'(seen), 32'd1);
    check_eq("t3_wr_hs", 32'(dut_wr), 32'(OUT_TOTAL));
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    check_eq("t3_no_33rd_wready", 32'(pe_wready), 32'd0);
    check_eq("t3_done_once", 32'(dut_done), 32'd1);

    // 4: abort after 5 input handshakes, then a clean frame
    clear_counts();
    step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 50 && dut_rd < 5; i++)
      step(1'b0, 1'b0, 1'b1, 1'b1, 1'($urandom % 2), 1'($urandom % 2), 1'b1);
    check_eq("t4_five_rd", 32'(dut_rd), 32'd5);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    check_eq("t4_abort_busy", 32'(busy), 32'd0);
    check_eq("t4_abort_rvalid", 32'(pe_rvalid), 32'd0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check_eq("t4_no_done", 32'(dut_done), 32'd0);
    clear_counts();
    step(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    run_until_done(200, 100, seen);
    check_eq("t4_done_seen", 32'(seen), 32'd1);
    check_eq("t4_rd_hs", 32'(dut_rd), 32'(IN_TOTAL));
    check_eq("t4_wr_hs", 32'(dut_wr), 32'(OUT_TOTAL));

    // 5: start held high through a done -> back-to-back frames
    clear_counts();
    gap = 0;
    for (int i = 0; i < 400; i++) begin
      step(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
      if (dut_done >= 2) break;
      if (dut_done == 1 && !busy) gap++;
    end
    check_eq("t5_two_frames", 32'(dut_done), 32'd2);
    check_eq("t5_idle_gap", 32'(gap), 32'd1);
    check_eq("t5_rd_hs", 32'(dut_rd), 32'(2 * IN_TOTAL));
    reset_cycle();

`ifdef UPSP_STALL_CNT_EN
    // 6: ten cycles of write back-pressure
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    repeat (10) step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    check_eq("t6_stall_10", stall_cnt, 32'd10);
    reset_cycle();
`endif

    // Random traffic with occasional start, abort and reset
    for (int i = 0; i < 4000; i++) begin
      step(($urandom % 4) == 0, ($urandom % 128) == 0,
           ($urandom % 100) < 75, ($urandom % 100) < 75,
           ($urandom % 100) < 75, ($urandom % 100) < 70,
           ($urandom % 256) != 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
